// File: rtl/cache_axi_arbiter_if.sv
// Cache-side bundle between the icache/dcache and the AXI bridge port.
// The slave modport is the arbiter's view; master is the caches/bridge model.
interface cache_axi_arbiter_if;
    logic         ic_rd_req;
    logic [2:0]   ic_rd_type;
    logic [31:0]  ic_rd_addr;
    logic         ic_rd_rdy;
    logic         ic_ret_valid;
    logic         ic_ret_last;
    logic [31:0]  ic_ret_data;

    logic         dc_rd_req;
    logic [2:0]   dc_rd_type;
    logic [31:0]  dc_rd_addr;
    logic         dc_rd_rdy;
    logic         dc_ret_valid;
    logic         dc_ret_last;
    logic [31:0]  dc_ret_data;

    logic         dc_wr_req;
    logic [2:0]   dc_wr_type;
    logic [31:0]  dc_wr_addr;
    logic [3:0]   dc_wr_wstrb;
    logic [127:0] dc_wr_data;
    logic         dc_wr_rdy;

    logic         mem_rd_req;
    logic [2:0]   mem_rd_type;
    logic [31:0]  mem_rd_addr;
    logic         mem_rd_rdy;
    logic         mem_ret_valid;
    logic         mem_ret_last;
    logic [31:0]  mem_ret_data;

    logic         mem_wr_req;
    logic [2:0]   mem_wr_type;
    logic [31:0]  mem_wr_addr;
    logic [3:0]   mem_wr_wstrb;
    logic [127:0] mem_wr_data;
    logic         mem_wr_rdy;

    modport slave (
        input  ic_rd_req, ic_rd_type, ic_rd_addr,
        output ic_rd_rdy, ic_ret_valid, ic_ret_last, ic_ret_data,
        input  dc_rd_req, dc_rd_type, dc_rd_addr,
        output dc_rd_rdy, dc_ret_valid, dc_ret_last, dc_ret_data,
        input  dc_wr_req, dc_wr_type, dc_wr_addr, dc_wr_wstrb, dc_wr_data,
        output dc_wr_rdy,
        output mem_rd_req, mem_rd_type, mem_rd_addr,
        input  mem_rd_rdy, mem_ret_valid, mem_ret_last, mem_ret_data,
        output mem_wr_req, mem_wr_type, mem_wr_addr, mem_wr_wstrb, mem_wr_data,
        input  mem_wr_rdy
    );

    modport master (
        output ic_rd_req, ic_rd_type, ic_rd_addr,
        input  ic_rd_rdy, ic_ret_valid, ic_ret_last, ic_ret_data,
        output dc_rd_req, dc_rd_type, dc_rd_addr,
        input  dc_rd_rdy, dc_ret_valid, dc_ret_last, dc_ret_data,
        output dc_wr_req, dc_wr_type, dc_wr_addr, dc_wr_wstrb, dc_wr_data,
        input  dc_wr_rdy,
        input  mem_rd_req, mem_rd_type, mem_rd_addr,
        output mem_rd_rdy, mem_ret_valid, mem_ret_last, mem_ret_data,
        input  mem_wr_req, mem_wr_type, mem_wr_addr, mem_wr_wstrb, mem_wr_data,
        output mem_wr_rdy
    );
endinterface

// File: rtl/cache_axi_arbiter.sv
// Round-robin read arbiter for icache/dcache onto one bridge port, plus a
// single-entry dcache write buffer that holds back reads to its line.
module cache_axi_arbiter (
    input logic               clk,
    input logic               reset,
    cache_axi_arbiter_if.slave bus
);
    typedef enum logic {R_IDLE, R_WAIT} rd_state_e;
    typedef enum logic {W_EMPTY, W_FULL} wr_state_e;

    localparam logic SEL_IC = 1'b0;
    localparam logic SEL_DC = 1'b1;

    rd_state_e    rd_state_q;
    wr_state_e    wr_state_q;
    logic         rr_last_q;
    logic         owner_q;
    logic [2:0]   wb_type_q;
    logic [31:0]  wb_addr_q;
    logic [3:0]   wb_wstrb_q;
    logic [127:0] wb_data_q;

    logic ic_elig, dc_elig, gnt_ic, gnt_dc, in_wait, wb_full;

    assign wb_full = (wr_state_q == W_FULL);
    assign in_wait = (rd_state_q == R_WAIT);

    // Any read touching the buffered line waits until the write drains.
    assign ic_elig = bus.ic_rd_req && !(wb_full && bus.ic_rd_addr[31:4] == wb_addr_q[31:4]);
    assign dc_elig = bus.dc_rd_req && !(wb_full && bus.dc_rd_addr[31:4] == wb_addr_q[31:4]);

    assign gnt_dc = !in_wait && dc_elig && (!ic_elig || rr_last_q == SEL_IC);
    assign gnt_ic = !in_wait && ic_elig && !gnt_dc;

    assign bus.mem_rd_req  = gnt_ic || gnt_dc;
    assign bus.mem_rd_type = gnt_dc ? bus.dc_rd_type : bus.ic_rd_type;
    assign bus.mem_rd_addr = gnt_dc ? bus.dc_rd_addr : bus.ic_rd_addr;
    assign bus.ic_rd_rdy   = gnt_ic && bus.mem_rd_rdy;
    assign bus.dc_rd_rdy   = gnt_dc && bus.mem_rd_rdy;

    assign bus.ic_ret_valid = in_wait && owner_q == SEL_IC && bus.mem_ret_valid;
    assign bus.ic_ret_last  = in_wait && owner_q == SEL_IC && bus.mem_ret_last;
    assign bus.dc_ret_valid = in_wait && owner_q == SEL_DC && bus.mem_ret_valid;
    assign bus.dc_ret_last  = in_wait && owner_q == SEL_DC && bus.mem_ret_last;
    assign bus.ic_ret_data  = bus.mem_ret_data;
    assign bus.dc_ret_data  = bus.mem_ret_data;

    assign bus.dc_wr_rdy    = (wr_state_q == W_EMPTY);
    assign bus.mem_wr_req   = wb_full && bus.mem_wr_rdy;
    assign bus.mem_wr_type  = wb_type_q;
    assign bus.mem_wr_addr  = wb_addr_q;
    assign bus.mem_wr_wstrb = wb_wstrb_q;
    assign bus.mem_wr_data  = wb_data_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_state_q <= R_IDLE;
            wr_state_q <= W_EMPTY;
            rr_last_q  <= SEL_IC;
            owner_q    <= SEL_DC;
            wb_type_q  <= '0;
            wb_addr_q  <= '0;
            wb_wstrb_q <= '0;
            wb_data_q  <= '0;
        end else begin
            case (rd_state_q)
                R_IDLE: if (bus.mem_rd_req && bus.mem_rd_rdy) begin
                    owner_q    <= gnt_dc;
                    rr_last_q  <= gnt_dc;
                    rd_state_q <= R_WAIT;
                end
                R_WAIT: if (bus.mem_ret_valid && bus.mem_ret_last) rd_state_q <= R_IDLE;
                default: rd_state_q <= R_IDLE;
            endcase
            case (wr_state_q)
                W_EMPTY: if (bus.dc_wr_req) begin
                    wb_type_q  <= bus.dc_wr_type;
                    wb_addr_q  <= bus.dc_wr_addr;
                    wb_wstrb_q <= bus.dc_wr_wstrb;
                    wb_data_q  <= bus.dc_wr_data;
                    wr_state_q <= W_FULL;
                end
                W_FULL: if (bus.mem_wr_rdy) wr_state_q <= W_EMPTY;
                default: wr_state_q <= W_EMPTY;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_axi_arbiter.sv
// Directed bench for cache_axi_arbiter: line read, round-robin, write drain,
// RAW hold-off, stray return and reset mid-burst.
module tb_cache_axi_arbiter;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad = 0;

    cache_axi_arbiter_if bus ();
    cache_axi_arbiter dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [127:0] WDATA = 128'hAAAA_AAAA_5555_5555_AAAA_AAAA_1234_5678;

    initial begin
        reset = 1'b1;
        bus.ic_rd_req = 0; bus.ic_rd_type = 0; bus.ic_rd_addr = 0;
        bus.dc_rd_req = 0; bus.dc_rd_type = 0; bus.dc_rd_addr = 0;
        bus.dc_wr_req = 0; bus.dc_wr_type = 0; bus.dc_wr_addr = 0;
        bus.dc_wr_wstrb = 0; bus.dc_wr_data = 0;
        bus.mem_rd_rdy = 0; bus.mem_ret_valid = 0; bus.mem_ret_last = 0;
        bus.mem_ret_data = 0; bus.mem_wr_rdy = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("rst_wr_rdy", bus.dc_wr_rdy, 1);
        chk("rst_mem_wr_req", bus.mem_wr_req, 0);
        chk("rst_mem_rd_req", bus.mem_rd_req, 0);
        chk("rst_ic_ret_valid", bus.ic_ret_valid, 0);
        chk("rst_dc_ret_valid", bus.dc_ret_valid, 0);

        // single icache line read
        bus.ic_rd_req = 1; bus.ic_rd_addr = 32'h1C00_0100; bus.ic_rd_type = 3'b100;
        bus.mem_rd_rdy = 1;
        #1;
        chk("t1_mem_rd_req", bus.mem_rd_req, 1);
        chk("t1_mem_rd_addr", bus.mem_rd_addr, 32'h1C00_0100);
        chk("t1_mem_rd_type", bus.mem_rd_type, 3'b100);
        chk("t1_ic_rd_rdy", bus.ic_rd_rdy, 1);
        chk("t1_dc_rd_rdy", bus.dc_rd_rdy, 0);
        tick();
        bus.ic_rd_req = 0;
        for (int i = 0; i < 4; i++) begin
            bus.mem_ret_valid = 1; bus.mem_ret_last = (i == 3);
            bus.mem_ret_data = 32'(8'h11 * (i + 1));
            #1;
            chk("t1_mem_rd_req_wait", bus.mem_rd_req, 0);
            chk("t1_ic_ret_valid", bus.ic_ret_valid, 1);
            chk("t1_ic_ret_data", bus.ic_ret_data, 32'(8'h11 * (i + 1)));
            chk("t1_ic_ret_last", bus.ic_ret_last, (i == 3));
            chk("t1_dc_ret_valid", bus.dc_ret_valid, 0);
            tick();
        end
        bus.mem_ret_valid = 0; bus.mem_ret_last = 0;

        // round robin with both requesting continuously: dc, ic, dc, ic
        bus.ic_rd_req = 1; bus.ic_rd_addr = 32'h1C00_0000; bus.ic_rd_type = 3'b010;
        bus.dc_rd_req = 1; bus.dc_rd_addr = 32'h0000_1000; bus.dc_rd_type = 3'b010;
        for (int k = 0; k < 4; k++) begin
            logic expdc;
            expdc = (k % 2 == 0);
            #1;
            chk("t2_dc_rd_rdy", bus.dc_rd_rdy, expdc);
            chk("t2_ic_rd_rdy", bus.ic_rd_rdy, !expdc);
            chk("t2_mem_rd_addr", bus.mem_rd_addr, expdc ? 32'h0000_1000 : 32'h1C00_0000);
            tick();
            bus.mem_ret_valid = 1; bus.mem_ret_last = 1; bus.mem_ret_data = 32'(k);
            #1;
            chk("t2_wait_no_req", bus.mem_rd_req, 0);
            chk("t2_wait_dc_rdy", bus.dc_rd_rdy, 0);
            chk("t2_dc_ret_valid", bus.dc_ret_valid, expdc);
            chk("t2_ic_ret_valid", bus.ic_ret_valid, !expdc);
            tick();
            bus.mem_ret_valid = 0; bus.mem_ret_last = 0;
        end
        bus.ic_rd_req = 0; bus.dc_rd_req = 0;

        // write capture and delayed drain
        bus.mem_wr_rdy = 0;
        bus.dc_wr_req = 1; bus.dc_wr_type = 3'b100; bus.dc_wr_addr = 32'h0000_2340;
        bus.dc_wr_wstrb = 4'hF; bus.dc_wr_data = WDATA;
        #1;
        chk("t3_wr_rdy_empty", bus.dc_wr_rdy, 1);
        tick();
        bus.dc_wr_req = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t3_wr_rdy_full", bus.dc_wr_rdy, 0);
            chk("t3_no_wr_req", bus.mem_wr_req, 0);
            tick();
        end
        bus.mem_wr_rdy = 1;
        #1;
        chk("t3_wr_req", bus.mem_wr_req, 1);
        chk("t3_wr_data", bus.mem_wr_data, WDATA);
        chk("t3_wr_addr", bus.mem_wr_addr, 32'h0000_2340);
        chk("t3_wr_type", bus.mem_wr_type, 3'b100);
        tick();
        #1;
        chk("t3_wr_req_once", bus.mem_wr_req, 0);
        chk("t3_wr_rdy_again", bus.dc_wr_rdy, 1);
        bus.mem_wr_rdy = 0;

        // RAW hazard against buffered line 0x2340
        bus.dc_wr_req = 1;
        tick();
        bus.dc_wr_req = 0;
        bus.dc_rd_req = 1; bus.dc_rd_addr = 32'h0000_2348; bus.dc_rd_type = 3'b010;
        bus.ic_rd_req = 1; bus.ic_rd_addr = 32'h1C00_0000; bus.ic_rd_type = 3'b010;
        #1;
        chk("t4_dc_blocked", bus.dc_rd_rdy, 0);
        chk("t4_ic_granted", bus.ic_rd_rdy, 1);
        chk("t4_ic_addr", bus.mem_rd_addr, 32'h1C00_0000);
        tick();
        bus.ic_rd_req = 0;
        bus.mem_ret_valid = 1; bus.mem_ret_last = 1; bus.mem_ret_data = 32'hCAFE;
        #1;
        chk("t4_ic_ret", bus.ic_ret_valid, 1);
        tick();
        bus.mem_ret_valid = 0; bus.mem_ret_last = 0;
        #1;
        chk("t4_dc_still_blocked", bus.dc_rd_rdy, 0);
        chk("t4_no_rd_req", bus.mem_rd_req, 0);
        bus.mem_wr_rdy = 1;
        #1;
        chk("t4_drain", bus.mem_wr_req, 1);
        chk("t4_dc_blocked_drain", bus.dc_rd_rdy, 0);
        tick();
        bus.mem_wr_rdy = 0;
        #1;
        chk("t4_dc_granted", bus.dc_rd_rdy, 1);
        chk("t4_dc_addr", bus.mem_rd_addr, 32'h0000_2348);
        tick();
        bus.dc_rd_req = 0;
        bus.mem_ret_valid = 1; bus.mem_ret_last = 1;
        #1;
        chk("t4_dc_ret", bus.dc_ret_valid, 1);
        tick();
        bus.mem_ret_valid = 0; bus.mem_ret_last = 0;

        // stray return in idle
        bus.mem_ret_valid = 1; bus.mem_ret_last = 1;
        #1;
        chk("t5_ic_ret", bus.ic_ret_valid, 0);
        chk("t5_dc_ret", bus.dc_ret_valid, 0);
        chk("t5_ic_last", bus.ic_ret_last, 0);
        tick();
        bus.mem_ret_valid = 0; bus.mem_ret_last = 0;

        // reset mid-burst with the buffer full
        bus.ic_rd_req = 1; bus.ic_rd_addr = 32'h1C00_0200; bus.ic_rd_type = 3'b100;
        bus.dc_wr_req = 1; bus.dc_wr_addr = 32'h0000_3000;
        #1;
        chk("t6_ic_granted", bus.ic_rd_rdy, 1);
        tick();
        bus.ic_rd_req = 0; bus.dc_wr_req = 0;
        for (int i = 0; i < 2; i++) begin
            bus.mem_ret_valid = 1; bus.mem_ret_last = 0;
            #1;
            chk("t6_beat", bus.ic_ret_valid, 1);
            tick();
        end
        bus.mem_ret_valid = 0;
        chk("t6_full_before_rst", bus.dc_wr_rdy, 0);
        reset = 1;
        tick();
        reset = 0;
        bus.mem_wr_rdy = 1; bus.mem_ret_valid = 1;
        #1;
        chk("t6_wr_rdy", bus.dc_wr_rdy, 1);
        chk("t6_no_wr_req", bus.mem_wr_req, 0);
        chk("t6_idle_ret", bus.ic_ret_valid, 0);
        chk("t6_no_rd_req", bus.mem_rd_req, 0);
        bus.mem_ret_valid = 0; bus.mem_wr_rdy = 0;
        bus.ic_rd_req = 1; bus.dc_rd_req = 1; bus.dc_rd_addr = 32'h0000_1000;
        #1;
        chk("t6_tie_dc", bus.dc_rd_rdy, 1);
        chk("t6_tie_ic", bus.ic_rd_rdy, 0);
        tick();
        bus.ic_rd_req = 0; bus.dc_rd_req = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cache_axi_arbiter.md
# cache_axi_arbiter

Shares the single cache-side read/write port of the AXI bridge between the instruction cache and the data cache. Serialises reads with round-robin priority, routes returned beats to the owning cache, and holds one data-cache write (line or uncached word) in a buffer. A read to a line still sitting in that write buffer is held back until the buffer drains.

## Interface
Parameters:
- none; all widths are fixed: addr 32, data beat 32, line 128, type 3, wstrb 4.

Ports:
- clk  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- ic_rd_req  in  1  icache read request.
- ic_rd_type  in  3  read type: 000 byte, 001 half, 010 word, 100 line.
- ic_rd_addr  in  32  read start address.
- ic_rd_rdy  out  1  icache read accepted this cycle.
- ic_ret_valid  out  1  return beat valid for icache.
- ic_ret_last  out  1  last beat for icache.
- ic_ret_data  out  32  return beat data.
- dc_rd_req, dc_rd_type, dc_rd_addr, dc_rd_rdy, dc_ret_valid, dc_ret_last, dc_ret_data: same as the ic_* ports, for the dcache.
- dc_wr_req  in  1  dcache write request.
- dc_wr_type  in  3  write type, same encoding as the read type.
- dc_wr_addr  in  32  write address.
- dc_wr_wstrb  in  4  byte mask; meaningful only for types 000, 001, 010.
- dc_wr_data  in  128  write data.
- dc_wr_rdy  out  1  write buffer can accept a write.
- mem_rd_req, mem_rd_type, mem_rd_addr  out  1/3/32  read request to the bridge.
- mem_rd_rdy  in  1  bridge accepts the read.
- mem_ret_valid, mem_ret_last, mem_ret_data  in  1/1/32  bridge return beats.
- mem_wr_req, mem_wr_type, mem_wr_addr, mem_wr_wstrb, mem_wr_data  out  1/3/32/4/128  write request to the bridge.
- mem_wr_rdy  in  1  bridge can take a write.

## Operation
Read FSM, states R_IDLE and R_WAIT:
- **R_IDLE**
  - A requester is eligible when its rd_req=1 and it has no hazard.
  - Hazard: wbuf_full=1 and rd_addr[31:4] equals wbuf_addr[31:4]. This applies to every read type.
  - Grant, combinational:
    - only one requester eligible: that one;
    - both eligible: the one with `rr_last` ≠ it (`rr_last` is the previous winner).
  - mem_rd_req=1 when any requester is granted. mem_rd_type and mem_rd_addr are muxed from the granted requester.
  - The granted requester's x_rd_rdy = mem_rd_rdy. The other requester's rd_rdy = 0.
  - When mem_rd_req & mem_rd_rdy:
    - latch owner = grant;
    - set `rr_last` = grant;
    - move to R_WAIT.
- **R_WAIT**
  - mem_rd_req=0; both rd_rdy=0.
  - ret_valid = mem_ret_valid on the owner's port, 0 on the other port. The same gating applies to ret_last.
  - ic_ret_data and dc_ret_data both carry mem_ret_data.
  - When mem_ret_valid & mem_ret_last: return to R_IDLE.
- mem_ret_valid arriving while in R_IDLE is ignored.

Write buffer, one entry, states W_EMPTY and W_FULL:
- dc_wr_rdy = (state==W_EMPTY). It depends only on registered state, so it satisfies the "rdy before req" rule of the cache.
- W_EMPTY & dc_wr_req:
  - capture type, addr, wstrb and data;
  - move to W_FULL.
- W_FULL: mem_wr_req = mem_wr_rdy, i.e. the request is raised only when the bridge already shows ready. mem_wr_* fields come from the buffer.
- W_FULL & mem_wr_rdy: the transfer completes that cycle; move to W_EMPTY.
- Capture and drain can never happen in the same cycle, because dc_wr_rdy=0 while full.

Independence and reset:
- Reads and writes proceed independently. A read to a different line may be issued while the buffer is full.
- Reset: R_IDLE, W_EMPTY, `rr_last`=ic, owner=dc. With `rr_last`=ic, the first tie goes to the dcache.
- Reset in the middle of a burst abandons it; the bridge is reset by the same signal.

## Timing
- All outputs are combinational from registered state and the current inputs. There are no added request-path latency cycles.
- Read accept: the x_rd_rdy→mem handshake completes in the cycle the request is granted and mem_rd_rdy=1.
- Returns: the first return beat is visible on the owner's port in the same cycle as mem_ret_valid.
- Back-to-back reads: the earliest new grant is the cycle after the last return beat.
- Write buffer:
  - a capture in cycle N makes mem_wr_req possible in cycle N+1;
  - a drain in cycle M makes dc_wr_rdy=1 in cycle M+1.
- A hazarded read becomes grantable in the cycle after the drain.
- Outputs immediately after reset:
  - dc_wr_rdy=1;
  - mem_wr_req=0;
  - mem_rd_req=0 unless a rd_req is asserted;
  - all ret_valid and ret_last = 0;
  - rd_rdy = 0 unless that requester is granted and mem_rd_rdy=1.

## Test plan
- **Single icache line read.** ic_rd_req, addr 0x1C000100, type 100, mem_rd_rdy=1 → mem_rd_addr=0x1C000100 the same cycle. Four beats 0x11..0x44 appear only on ic_ret_*, ic_ret_last on the 4th beat. dc_ret_valid stays 0.
- **Simultaneous requests, round-robin.** Both request every cycle after reset → grant order dc, ic, dc, ic. Each grant waits for ret_last of the previous read.
- **Write then drain.** dc_wr_req, addr 0x00002340, type 100, data 128'hA..., mem_wr_rdy=0 for 3 cycles then 1 → dc_wr_rdy=0 from the next cycle. mem_wr_req=1 exactly one cycle, with the captured data. dc_wr_rdy=1 the cycle after.
- **RAW hazard.** Buffer holds line 0x00002340 and mem_wr_rdy=0; dc_rd_req to 0x00002348 → no grant and dc_rd_rdy=0. An ic read to 0x1C000000 in the same cycle is granted. The dc read is granted the cycle after the drain.
- **Stray return.** mem_ret_valid pulse in R_IDLE → no ret_valid on either port and no state change.
- **Reset mid-burst.** Reset after the 2nd beat of an ic read with the buffer full → after reset: R_IDLE, dc_wr_rdy=1, mem_wr_req=0. The first tie goes to dc.
